fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited imem requests and a
// 2-entry in-order instruction buffer with redirect flush and stale-response drain.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        nop
);
  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [1:0]  out_reg, out_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [1:0]  drop_reg, drop_next;
  logic        rd_ptr_reg, wr_ptr_reg;
  logic [31:0] fifo_pc_reg    [2];
  logic [31:0] fifo_instr_reg [2];

  logic        fifo_nempty, pop, push;
  logic [2:0]  credit;
  logic [1:0]  out_after_resp;
  logic [31:0] resp_addr;

  assign fifo_nempty    = (cnt_reg != 2'd0);
  assign pop            = fifo_nempty && !stall && !redirect;
  assign credit         = {1'b0, out_reg} + {1'b0, cnt_reg} - {2'b00, pop};
  assign imem_req       = !rst && (state_reg == RUN) && !redirect && (credit < 3'd2);
  assign imem_addr      = pc_reg;
  assign push           = (state_reg == RUN) && imem_valid && !redirect;
  assign out_after_resp = out_reg - {1'b0, imem_valid};

  // In RUN every outstanding request is a consecutive word ending just below pc_reg,
  // so the oldest one (the one being answered) sits out_reg words back.
  assign resp_addr = pc_reg - {28'd0, out_reg, 2'b00};

  assign nop         = rst || !fifo_nempty || redirect;
  assign instruction = nop ? 32'h0 : fifo_instr_reg[rd_ptr_reg];
  assign pc_out      = nop ? 32'h0 : fifo_pc_reg[rd_ptr_reg];

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    out_next   = out_after_resp + {1'b0, imem_req};
    cnt_next   = cnt_reg + {1'b0, push} - {1'b0, pop};
    drop_next  = drop_reg;
    if (redirect) begin
      // A response landing in the redirect cycle is discarded and no longer owed.
      pc_next    = redirect_pc & ~32'h3;
      cnt_next   = 2'd0;
      drop_next  = out_after_resp;
      state_next = (out_after_resp != 2'd0) ? DRAIN : RUN;
    end else if (state_reg == DRAIN) begin
      if (imem_valid) begin
        drop_next = drop_reg - 2'd1;
        if (drop_reg == 2'd1)
          state_next = RUN;
      end
    end else if (imem_req) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC & ~32'h3;
      out_reg    <= 2'd0;
      cnt_reg    <= 2'd0;
      drop_reg   <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
      drop_reg  <= drop_next;
      if (redirect) begin
        rd_ptr_reg <= 1'b0;
        wr_ptr_reg <= 1'b0;
      end else begin
        if (push)
          wr_ptr_reg <= !wr_ptr_reg;
        if (pop)
          rd_ptr_reg <= !rd_ptr_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc_reg[wr_ptr_reg]    <= resp_addr;
      fifo_instr_reg[wr_ptr_reg] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency in-order memory plus a queue-based
// reference of fetch order, buffered instructions and stale responses.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        nop;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instruction(instruction), .pc_out(pc_out), .nop(nop)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  mreq_t       memq[$];
  ent_t        fq[$];
  logic [31:0] fetch_pc, exp_pc;
  int          cyc, last_due, lat_min, lat_max;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        obs_req, obs_nop;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic reset_model();
    memq.delete();
    fq.delete();
    fetch_pc = RESET_PC;
    exp_pc   = RESET_PC;
    last_due = -1;
    cyc      = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    end
    reset_model();
  endtask

  // One clock of stimulus; the memory and the reference queues advance together.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    int    fresh, stale, lat, due;
    logic  popx, exp_nop, exp_req;
    mreq_t m;
    ent_t  e;
    @(negedge clk);
    rst = 1'b0; stall = st; redirect = rd; redirect_pc = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_valid = 1'b1; imem_data = memdata(memq[0].addr);
    end else begin
      imem_valid = 1'b0; imem_data = $urandom;
    end
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_nop = nop; obs_pc = pc_out;
    fresh = 0; stale = 0;
    foreach (memq[i]) if (memq[i].stale) stale++; else fresh++;
    popx    = (fq.size() > 0) && !st && !rd;
    exp_nop = (fq.size() == 0) || rd;
    exp_req = !rd && (stale == 0) && ((fresh + fq.size() - (popx ? 1 : 0)) < 2);

    n_checks++;
    if (nop !== exp_nop) begin
      n_fail++; $display("FAIL nop cyc=%0d got=%b want=%b", cyc, nop, exp_nop);
    end
    if (exp_nop) begin
      n_checks++;
      if (pc_out !== 32'h0 || instruction !== 32'h0) begin
        n_fail++; $display("FAIL nop_zero cyc=%0d pc=%h ins=%h want 0", cyc, pc_out, instruction);
      end
    end else begin
      n_checks++;
      if (pc_out !== fq[0].pc || instruction !== fq[0].ins) begin
        n_fail++;
        $display("FAIL head cyc=%0d pc=%h ins=%h want pc=%h ins=%h", cyc, pc_out, instruction, fq[0].pc, fq[0].ins);
      end
      n_checks++;
      if (pc_out !== exp_pc) begin
        n_fail++; $display("FAIL pc_seq cyc=%0d got=%h want=%h", cyc, pc_out, exp_pc);
      end
    end
    n_checks++;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
    end
    if (imem_req === 1'b1) begin
      n_checks++;
      if (imem_addr !== fetch_pc) begin
        n_fail++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, fetch_pc);
      end
    end
    n_checks++;
    if (fresh + fq.size() > 2) begin
      n_fail++; $display("FAIL occupancy cyc=%0d got=%0d want<=2", cyc, fresh + fq.size());
    end

    if (popx) begin
      void'(fq.pop_front());
      exp_pc += 32'd4;
    end
    if (imem_valid) begin
      m = memq.pop_front();
      if (!m.stale && !rd) begin
        e.pc = m.addr; e.ins = memdata(m.addr);
        fq.push_back(e);
      end
    end
    if (rd) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      fq.delete();
      fetch_pc = rpc & ~32'h3;
      exp_pc   = rpc & ~32'h3;
    end else if (imem_req === 1'b1) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = imem_addr; m.due = due; m.stale = 1'b0;
      memq.push_back(m);
      fetch_pc += 32'd4;
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b1; stall = (i % 2 == 1); redirect = (i == 2); redirect_pc = 32'h40;
      imem_valid = (i == 1); imem_data = 32'hDEAD_0000;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || nop !== 1'b1 || instruction !== 32'h0 || pc_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_out i=%0d req=%b nop=%b ins=%h pc=%h want 0/1/0/0", i, imem_req, nop, instruction, pc_out);
      end
    end
    reset_model();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_req req=%b addr=%h want 1/%h", obs_req, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'(i * 4)) begin
        n_fail++; $display("FAIL stream_req i=%0d req=%b addr=%h want 1/%h", i, obs_req, obs_addr, i * 4);
      end
      n_checks++;
      if (i >= 2 ? (obs_nop !== 1'b0 || obs_pc !== 32'((i - 2) * 4)) : (obs_nop !== 1'b1)) begin
        n_fail++; $display("FAIL stream_out i=%0d nop=%b pc=%h", i, obs_nop, obs_pc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    frozen = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (i == 0) frozen = obs_pc;
      n_checks++;
      if (obs_req !== 1'b0 || obs_nop !== 1'b0 || obs_pc !== frozen) begin
        n_fail++; $display("FAIL stall_hold i=%0d req=%b nop=%b pc=%h want 0/0/%h", i, obs_req, obs_nop, obs_pc, frozen);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (obs_nop !== 1'b0 || obs_pc !== frozen + 32'(4 * j)) begin
        n_fail++; $display("FAIL stall_release j=%0d pc=%h want %h", j, obs_pc, frozen + 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103);
    n_checks++;
    if (obs_nop !== 1'b1 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle nop=%b req=%b want 1/0", obs_nop, obs_req);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_req === 1'b1) found = 1;
    end
    n_checks++;
    if (!found || obs_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL redir_req found=%0d addr=%h want 00000100", found, obs_addr);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_nop === 1'b0) found = 1;
    end
    n_checks++;
    if (!found || obs_pc !== 32'h0000_0100) begin
      n_fail++; $display("FAIL redir_present found=%0d pc=%h want 00000100", found, obs_pc);
    end
  endtask

  task automatic test_redirect_valid_stall();
    bit found;
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (obs_nop !== 1'b1 || obs_req !== 1'b1 || obs_addr !== 32'h0000_0040) begin
      n_fail++; $display("FAIL rvs_after nop=%b req=%b addr=%h want 1/1/00000040", obs_nop, obs_req, obs_addr);
    end
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_nop === 1'b0) found = 1;
    end
    n_checks++;
    if (!found || obs_pc !== 32'h0000_0040) begin
      n_fail++; $display("FAIL rvs_present found=%0d pc=%h want 00000040", found, obs_pc);
    end
  endtask

  task automatic test_drain_redirect();
    int idle;
    bit found;
    do_reset();
    lat_min = 4; lat_max = 4;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b1, 32'h0000_0200);
    idle = 0; found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_req === 1'b1) found = 1; else idle++;
    end
    n_checks++;
    if (!found || obs_addr !== 32'h0000_0200 || idle != 2) begin
      n_fail++; $display("FAIL drain_req found=%0d addr=%h idle=%0d want 00000200 after 2", found, obs_addr, idle);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    logic [31:0] want[3];
    do_reset();
    lat_min = 2; lat_max = 2;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    step(1'b0, 1'b1, 32'hFFFF_FFF9);
    for (int i = 0; i < 15 && seen.size() < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (obs_nop === 1'b0) seen.push_back(obs_pc);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= seen.size() || seen[k] !== want[k]) begin
        n_fail++; $display("FAIL wrap k=%0d got=%h want=%h", k, (k < seen.size()) ? seen[k] : 32'hX, want[k]);
      end
    end
  endtask

  task automatic test_random();
    logic st, rd;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      st = ($urandom_range(99, 0) < 30);
      rd = ($urandom_range(99, 0) < 6);
      step(st, rd, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_valid_stall();
    test_drain_redirect();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
